// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO buffer family.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DEFAULT_ADDRESS_WIDTH = 3;

  // Geometry of the default (8-entry) configuration.
  localparam int DEPTH     = 2 ** DEFAULT_ADDRESS_WIDTH;
  localparam int CNT_WIDTH = DEFAULT_ADDRESS_WIDTH + 1;

  // Default programmable thresholds.
  localparam int DEFAULT_AF_THRESH = DEPTH - 1;
  localparam int DEFAULT_AE_THRESH = 1;

  // Smallest n with 2**n >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int n;
    n = 0;
    while ((1 << n) < value) begin
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Storage for the FIFO: one write port, one registered read port.
module fifo_dpram #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  localparam int DEPTH_L = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH_L];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array is written on accepted pushes only and is never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register captures the addressed word only on an accepted pop.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Read data register; cleared by reset, otherwise holds between pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO buffer: pointers, occupancy count, status flags and
// sticky error bits around a fifo_dpram storage array.
module sync_fifo_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int AF_THRESH     = (2 ** ADDRESS_WIDTH) - 1,
  parameter int AE_THRESH     = DEFAULT_AE_THRESH
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CLR,
  input  logic [DATA_WIDTH-1:0]   WR_DATA,
  input  logic                    W_INC,
  input  logic                    R_INC,
  output logic [DATA_WIDTH-1:0]   RD_DATA,
  output logic                    RD_VALID,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic                    ALMOST_FULL,
  output logic                    ALMOST_EMPTY,
  output logic [ADDRESS_WIDTH:0]  COUNT,
  output logic                    OVERFLOW,
  output logic                    UNDERFLOW
);

  localparam int FIFO_DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int CNT_W      = ADDRESS_WIDTH + 1;

  localparam logic [CNT_W-1:0]         DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]         AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]         AE_C    = CNT_W'(AE_THRESH);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = ADDRESS_WIDTH'(1);
  localparam logic [CNT_W-1:0]         CNT_ONE = CNT_W'(1);

  // Reject illegal parameterisations at elaboration.
  if (ADDRESS_WIDTH < 1 || ADDRESS_WIDTH > 10) begin : g_bad_aw
    $error("sync_fifo_buf: ADDRESS_WIDTH must be in 1..10");
  end
  if (clog2(FIFO_DEPTH) != ADDRESS_WIDTH) begin : g_bad_depth
    $error("sync_fifo_buf: depth is not 2**ADDRESS_WIDTH");
  end
  if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
    $error("sync_fifo_buf: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_buf: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [ADDRESS_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDRESS_WIDTH-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic                     udf_q, udf_d;
  logic                     rd_valid_q, rd_valid_d;

  logic full, empty;
  logic wr_en, rd_en;
  logic mem_we, mem_re;

  // Flags decode the registered count, so no input reaches an output.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Full blocks writes and empty blocks reads; a read frees a slot only
  // on the following edge, so there is no pass-through in either case.
  assign wr_en = W_INC & ~full;
  assign rd_en = R_INC & ~empty;

  // Flush wins over both requests; RD_DATA is left untouched by it.
  assign mem_we = wr_en & ~CLR;
  assign mem_re = rd_en & ~CLR;

  // Next-state for pointers, count, read-valid pulse and sticky errors.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    rd_valid_d = 1'b0;
    if (CLR) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_en) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (rd_en) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      ovf_d      = ovf_q | (W_INC & full);
      udf_d      = udf_q | (R_INC & empty);
      rd_valid_d = rd_en;
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_dpram #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_mem (
    .clk  (CLK),
    .rst_n(RST),
    .we   (mem_we),
    .waddr(wptr_q),
    .wdata(WR_DATA),
    .re   (mem_re),
    .raddr(rptr_q),
    .rdata(RD_DATA)
  );

  assign RD_VALID     = rd_valid_q;
  assign FULL         = full;
  assign EMPTY        = empty;
  assign ALMOST_FULL  = (count_q >= AF_C);
  assign ALMOST_EMPTY = (count_q <= AE_C);
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Testbench for sync_fifo_buf: default 8x8 instance and a 16x16 instance
// with custom thresholds, both checked against a queue-based model.
module tb_sync_fifo_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        clr_a, w_a, r_a;
  logic [7:0]  wd_a, rd_a;
  logic        rv_a, full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic [3:0]  cnt_a;

  logic        clr_b, w_b, r_b;
  logic [15:0] wd_b, rd_b;
  logic        rv_b, full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
  logic [4:0]  cnt_b;

  sync_fifo_buf u_a (
    .CLK(clk), .RST(rst_n), .CLR(clr_a), .WR_DATA(wd_a), .W_INC(w_a),
    .R_INC(r_a), .RD_DATA(rd_a), .RD_VALID(rv_a), .FULL(full_a),
    .EMPTY(empty_a), .ALMOST_FULL(af_a), .ALMOST_EMPTY(ae_a),
    .COUNT(cnt_a), .OVERFLOW(ovf_a), .UNDERFLOW(udf_a)
  );

  sync_fifo_buf #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(4), .AF_THRESH(12), .AE_THRESH(3)
  ) u_b (
    .CLK(clk), .RST(rst_n), .CLR(clr_b), .WR_DATA(wd_b), .W_INC(w_b),
    .R_INC(r_b), .RD_DATA(rd_b), .RD_VALID(rv_b), .FULL(full_b),
    .EMPTY(empty_b), .ALMOST_FULL(af_b), .ALMOST_EMPTY(ae_b),
    .COUNT(cnt_b), .OVERFLOW(ovf_b), .UNDERFLOW(udf_b)
  );

  // Reference model: contents as a queue, plus expected sticky/read state.
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int          depth_m[2] = '{8, 16};
  int          af_m[2]    = '{7, 12};
  int          ae_m[2]    = '{1, 3};
  bit          m_ovf[2], m_udf[2], m_rv[2];
  logic [15:0] m_rd[2];

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    for (int k = 0; k < 2; k++) begin
      m_ovf[k] = 1'b0; m_udf[k] = 1'b0; m_rv[k] = 1'b0; m_rd[k] = '0;
    end
  endtask

  task automatic model_update(input int sel, input bit w, input bit r,
                              input bit c, input logic [15:0] d);
    int n;
    bit full, empty;
    n     = (sel == 0) ? qa.size() : qb.size();
    full  = (n == depth_m[sel]);
    empty = (n == 0);
    if (c) begin
      if (sel == 0) qa.delete(); else qb.delete();
      m_ovf[sel] = 1'b0;
      m_udf[sel] = 1'b0;
      m_rv[sel]  = 1'b0;
    end else begin
      if (w && full)  m_ovf[sel] = 1'b1;
      if (r && empty) m_udf[sel] = 1'b1;
      m_rv[sel] = r && !empty;
      if (m_rv[sel]) m_rd[sel] = (sel == 0) ? qa.pop_front() : qb.pop_front();
      if (w && !full) begin
        if (sel == 0) qa.push_back({8'h00, d[7:0]}); else qb.push_back(d);
      end
    end
  endtask

  task automatic check_outputs(input int sel);
    int n;
    string p;
    n = (sel == 0) ? qa.size() : qb.size();
    p = (sel == 0) ? "A" : "B";
    if (sel == 0) begin
      chk({p, ".count"}, 32'(cnt_a), 32'(n));
      chk({p, ".full"},  32'(full_a),  32'(n == depth_m[0]));
      chk({p, ".empty"}, 32'(empty_a), 32'(n == 0));
      chk({p, ".afull"}, 32'(af_a),    32'(n >= af_m[0]));
      chk({p, ".aempty"},32'(ae_a),    32'(n <= ae_m[0]));
      chk({p, ".ovf"},   32'(ovf_a),   32'(m_ovf[0]));
      chk({p, ".udf"},   32'(udf_a),   32'(m_udf[0]));
      chk({p, ".rvalid"},32'(rv_a),    32'(m_rv[0]));
      chk({p, ".rdata"}, 32'(rd_a),    32'(m_rd[0][7:0]));
    end else begin
      chk({p, ".count"}, 32'(cnt_b), 32'(n));
      chk({p, ".full"},  32'(full_b),  32'(n == depth_m[1]));
      chk({p, ".empty"}, 32'(empty_b), 32'(n == 0));
      chk({p, ".afull"}, 32'(af_b),    32'(n >= af_m[1]));
      chk({p, ".aempty"},32'(ae_b),    32'(n <= ae_m[1]));
      chk({p, ".ovf"},   32'(ovf_b),   32'(m_ovf[1]));
      chk({p, ".udf"},   32'(udf_b),   32'(m_udf[1]));
      chk({p, ".rvalid"},32'(rv_b),    32'(m_rv[1]));
      chk({p, ".rdata"}, 32'(rd_b),    32'(m_rd[1]));
    end
  endtask

  // One clock of stimulus on the selected instance, then a full check.
  task automatic step(input int sel, input bit w, input bit r, input bit c,
                      input logic [15:0] d);
    @(negedge clk);
    if (sel == 0) begin
      w_a = w; r_a = r; clr_a = c; wd_a = d[7:0];
    end else begin
      w_b = w; r_b = r; clr_b = c; wd_b = d;
    end
    @(posedge clk);
    model_update(sel, w, r, c, d);
    #1;
    check_outputs(sel);
    w_a = 1'b0; r_a = 1'b0; clr_a = 1'b0;
    w_b = 1'b0; r_b = 1'b0; clr_b = 1'b0;
  endtask

  task automatic random_run(input int sel, input int n_steps);
    int wp;
    for (int i = 0; i < n_steps; i++) begin
      wp = ((i / 40) % 2 == 0) ? 75 : 25;
      step(sel, $urandom_range(0, 99) < wp, $urandom_range(0, 99) >= wp - 10,
           $urandom_range(0, 59) == 0, 16'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr_a = 1'b0; w_a = 1'b0; r_a = 1'b0; wd_a = '0;
    clr_b = 1'b0; w_b = 1'b0; r_b = 1'b0; wd_b = '0;
    model_reset();
    #3;
    check_outputs(0);
    check_outputs(1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with 0x11..0x88, then one rejected write.
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 0, 16'(i * 16 + i));
    step(0, 1, 0, 0, 16'h0099);

    // Drain in order, then one rejected read.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0);

    // Simultaneous push/pop at count 3 across pointer wrap.
    step(0, 0, 0, 1, 16'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 16'($urandom));
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 16'($urandom));

    // Both requests when full, then both when empty.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 16'($urandom));
    step(0, 1, 1, 0, 16'h00A5);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 16'h0);
    step(0, 1, 1, 0, 16'h005A);
    step(0, 0, 1, 0, 16'h0);

    // Flush at count 5 with overflow set; the concurrent write is dropped.
    step(0, 0, 0, 1, 16'h0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 16'(8'h30 + i));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 16'h0);
    step(0, 1, 0, 1, 16'h00EE);
    step(0, 1, 0, 0, 16'h0042);
    step(0, 0, 1, 0, 16'h0);

    // Asynchronous reset between edges at count 4.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 16'(8'hC0 + i));
    for (int i = 0; i < 2; i++) step(1, 1, 0, 0, 16'(16'hBEE0 + i));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(0);
    check_outputs(1);
    @(negedge clk);
    rst_n = 1'b1;

    random_run(0, 400);

    // Wider, deeper instance: threshold crossings on fill and drain.
    step(1, 0, 0, 1, 16'h0);
    for (int i = 0; i < 17; i++) step(1, 1, 0, 0, 16'(16'h1000 + i * 16'h0111));
    for (int i = 0; i < 17; i++) step(1, 0, 1, 0, 16'h0);
    random_run(1, 400);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
